time_param_sequencer: RTL and testbench
=======================================

# time_param_sequencer

Operator-facing configuration controller for the traffic-light timing datapath. It lets an operator step through the four time parameters, edit 4-bit values in shadow registers, and commit them. On commit it drives the time-parameter store's reprogram port one parameter at a time, and only while the light FSM reports a safe phase. It sits between the synchronized front-panel inputs and the time-parameter store, in place of direct switch wiring of `reprogram`, `time_param_selector` and `time_value`.

## Interface
- `TIMEOUT_S`, default 15: edit-session inactivity timeout, in `enable_1Hz` ticks (1..255).
- `DEF_BASE`, default 6: power-on and reset value of parameter 00 (base interval).
- `DEF_EXT`, default 3: reset value of parameter 01 (extended interval).
- `DEF_YEL`, default 2: reset value of parameter 10 (yellow interval).
- `DEF_WALK`, default 3: reset value of parameter 11 (walk interval).

Ports (clock and reset first):
- `clock` input 1: system clock; every register updates on its rising edge.
- `reset` input 1: synchronous, active-high; takes effect on the next rising edge of `clock`.
- `enable_1Hz` input 1: one-cycle tick from the divider.
- `edit_btn` input 1: synchronized level; a rising edge enters or leaves edit mode.
- `next_btn` input 1: synchronized level; a rising edge selects the next parameter.
- `inc_btn` input 1: synchronized level; a rising edge increments the selected value.
- `fsm_safe` input 1: high while the light FSM is in a phase where reprogramming is allowed.
- `prog_pulse` output 1: one-cycle reprogram strobe to the parameter store.
- `time_param_selector` output 2: parameter index, valid when `prog_pulse` = 1.
- `time_value` output 4: parameter value, valid when `prog_pulse` = 1.
- `editing` output 1: high in the EDIT state.
- `busy` output 1: high in the WAIT_SAFE and WRITE states.
- `cur_sel` output 2: parameter currently selected for display.
- `cur_val` output 4: shadow value of `cur_sel`, for display.

## Operation
- Each button has its own registered previous-value flop. An event is `btn & ~btn_q`. Buttons held high generate no repeat events.
- Registers:
  - `committed[0..3]`: the values last written to the store.
  - `shadow[0..3]`: the values being edited.
  - `sel`: a 2-bit index.
  - a timeout counter, 8 bits wide.
  - a write index `widx`, 2 bits wide.
- States:
  - IDLE
    - Entered on reset.
    - An `edit_btn` event copies `committed` into `shadow`, sets `sel` to 0, clears the timeout counter, and moves to EDIT.
    - `next_btn` and `inc_btn` events are ignored.
  - EDIT
    - A `next_btn` event sets `sel` to `sel+1` (mod 4). After 11 the index wraps to 00.
    - An `inc_btn` event sets `shadow[sel]` to `shadow[sel]+1`. The value 15 wraps to 1; 0 is never produced.
    - Any button event clears the timeout counter. An `enable_1Hz` tick with no event in the same cycle increments it.
    - Timeout: when the counter reaches `TIMEOUT_S`, the state returns to IDLE and `shadow` is discarded. No write occurs.
    - An `edit_btn` event moves the state to WAIT_SAFE.
  - WAIT_SAFE
    - Waits while `fsm_safe` = 0, ignoring all buttons.
    - When `fsm_safe` = 1, sets `widx` to 0 and moves to WRITE.
  - WRITE
    - Writes the parameters in order 00, 01, 10, 11.
    - Each write is one `prog_pulse` cycle followed by one gap cycle.
    - On each pulse, `committed[widx]` is set to `shadow[widx]`.
    - After the gap following index 11, the state returns to IDLE.
    - If `fsm_safe` falls mid-sequence, the writes still complete. The sequence is never split.
- Simultaneous events in one cycle have this priority: `edit_btn` > `inc_btn` > `next_btn`. Lower-priority events are dropped.
- Reset in any state:
  - the state returns to IDLE;
  - `committed` and `shadow` are set to the `DEF_*` values;
  - `sel` = 0 and the timeout counter = 0;
  - no `prog_pulse` is issued, including in the cycle reset is asserted.
- Display outputs:
  - In EDIT, `cur_val` = `shadow[sel]`. Otherwise `cur_val` = `committed[sel]`.
  - `sel` is retained across sessions only until the next `edit_btn` entry, which resets it to 0.

## Timing
- All outputs are registered. Button-event response latency is 1 cycle after the edge edge is sampled.
- Reset values of the outputs:
  - `prog_pulse`, `editing` and `busy` = 0;
  - `time_param_selector` = 00 and `time_value` = `DEF_BASE`;
  - `cur_sel` = 00 and `cur_val` = `DEF_BASE`.
- `time_param_selector` and `time_value` are held from one pulse through its gap cycle. They change only at the next pulse.
- Full write sequence: 8 cycles from WRITE entry to IDLE. `busy` stays high throughout, including the final gap cycle.
- Timeout granularity is in ticks. The abort happens in the cycle after the `TIMEOUT_S`-th idle tick.

## Test plan
- Reset with defaults, then enter and exit edit with no changes while `fsm_safe` = 1 -> four pulses carrying (00,6), (01,3), (10,2), (11,3), spaced 2 cycles apart. `busy` is high for 8 cycles.
- Enter edit, press `next_btn` twice, press `inc_btn` 14 times, then commit -> yellow counts up through 3..15 and wraps to 1. The pulse for index 10 carries value 1.
- Commit while `fsm_safe` = 0 for 50 cycles -> no pulse and `busy` = 1. Pulses start 1 cycle after `fsm_safe` rises.
- Enter edit, press `inc_btn` once on base, then apply 15 ticks with no buttons -> the block returns to IDLE with zero pulses. `cur_val` shows 6.
- Assert reset during the WRITE pulse for index 01 -> no further pulses. Outputs return to their reset values, and `committed` is back to the defaults.
- Raise `edit_btn` and `inc_btn` in the same cycle while in EDIT -> the state goes to WAIT_SAFE and the shadow value is unchanged. Holding `inc_btn` high for 100 cycles produces exactly one increment.

Source files
------------

// File: rtl/time_param_sequencer.sv
// time_param_sequencer
// Operator-facing editor for the four traffic-light time parameters. The
// operator edits 4-bit shadow copies, then commits them. The commit waits
// for a safe light phase and writes parameters 00..11 to the store as one
// unbroken pulse/gap sequence.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   enable_1Hz          one-cycle tick that drives the edit inactivity timeout
//   edit_btn            rising edge enters edit mode, or commits from it
//   next_btn            rising edge selects the next parameter
//   inc_btn             rising edge increments the selected value
//   fsm_safe            high when the light FSM allows reprogramming
//   prog_pulse          one-cycle reprogram strobe to the parameter store
//   time_param_selector parameter index carried with prog_pulse
//   time_value          parameter value carried with prog_pulse
//   editing / busy      state indicators (EDIT / WAIT_SAFE or WRITE)
//   cur_sel / cur_val   selected parameter and its value, for display
module time_param_sequencer #(
    parameter int unsigned TIMEOUT_S = 15,
    parameter logic [3:0]  DEF_BASE  = 4'd6,
    parameter logic [3:0]  DEF_EXT   = 4'd3,
    parameter logic [3:0]  DEF_YEL   = 4'd2,
    parameter logic [3:0]  DEF_WALK  = 4'd3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable_1Hz,
    input  logic       edit_btn,
    input  logic       next_btn,
    input  logic       inc_btn,
    input  logic       fsm_safe,
    output logic       prog_pulse,
    output logic [1:0] time_param_selector,
    output logic [3:0] time_value,
    output logic       editing,
    output logic       busy,
    output logic [1:0] cur_sel,
    output logic [3:0] cur_val
);

    typedef enum logic [1:0] {S_IDLE, S_EDIT, S_WAIT_SAFE, S_WRITE} state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT_S);

    state_t     state_q, state_d;
    logic [3:0] committed_q [4];
    logic [3:0] committed_d [4];
    logic [3:0] shadow_q [4];
    logic [3:0] shadow_d [4];
    logic [1:0] sel_q, sel_d;
    logic [1:0] widx_q, widx_d;
    logic [7:0] tmo_q, tmo_d;
    logic       gap_q, gap_d;
    logic       edit_q, next_q, inc_q;
    logic       edit_ev, next_ev, inc_ev;

    logic       prog_pulse_q, pulse_d;
    logic [1:0] tps_q, tps_d;
    logic [3:0] tv_q, tv_d;
    logic       editing_q, busy_q;
    logic [1:0] cur_sel_q;
    logic [3:0] cur_val_q, cur_val_d;

    assign edit_ev = edit_btn & ~edit_q;
    assign next_ev = next_btn & ~next_q;
    assign inc_ev  = inc_btn  & ~inc_q;

    always_comb begin
        state_d     = state_q;
        committed_d = committed_q;
        shadow_d    = shadow_q;
        sel_d       = sel_q;
        widx_d      = widx_q;
        tmo_d       = tmo_q;
        gap_d       = gap_q;

        case (state_q)
            S_IDLE: begin
                if (edit_ev) begin
                    shadow_d = committed_q;
                    sel_d    = 2'd0;
                    tmo_d    = '0;
                    state_d  = S_EDIT;
                end
            end
            S_EDIT: begin
                // edit > inc > next; lower-priority events are dropped
                if (edit_ev) begin
                    tmo_d   = '0;
                    state_d = S_WAIT_SAFE;
                end else if (inc_ev) begin
                    tmo_d = '0;
                    shadow_d[sel_q] = (shadow_q[sel_q] == 4'hF) ? 4'h1
                                                                : shadow_q[sel_q] + 4'h1;
                end else if (next_ev) begin
                    tmo_d = '0;
                    sel_d = sel_q + 2'd1;
                end else if (enable_1Hz) begin
                    if (tmo_q + 8'd1 == TMO) begin
                        tmo_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        tmo_d = tmo_q + 8'd1;
                    end
                end
            end
            S_WAIT_SAFE: begin
                if (fsm_safe) begin
                    widx_d  = 2'd0;
                    gap_d   = 1'b0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // fsm_safe is deliberately not sampled here: once started,
                // all four writes complete.
                if (!gap_q) begin
                    gap_d = 1'b1;
                end else if (widx_q == 2'd3) begin
                    gap_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    gap_d  = 1'b0;
                    widx_d = widx_q + 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from next-state values so they register on the
        // same edge as the state they describe.
        pulse_d = (state_d == S_WRITE) && !gap_d;
        tps_d   = tps_q;
        tv_d    = tv_q;
        if (pulse_d) begin
            committed_d[widx_d] = shadow_q[widx_d];
            tps_d               = widx_d;
            tv_d                = shadow_q[widx_d];
        end
        cur_val_d = (state_d == S_EDIT) ? shadow_d[sel_d] : committed_d[sel_d];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            committed_q  <= '{DEF_BASE, DEF_EXT, DEF_YEL, DEF_WALK};
            shadow_q     <= '{DEF_BASE, DEF_EXT, DEF_YEL, DEF_WALK};
            sel_q        <= '0;
            widx_q       <= '0;
            tmo_q        <= '0;
            gap_q        <= 1'b0;
            edit_q       <= 1'b0;
            next_q       <= 1'b0;
            inc_q        <= 1'b0;
            prog_pulse_q <= 1'b0;
            tps_q        <= '0;
            tv_q         <= DEF_BASE;
            editing_q    <= 1'b0;
            busy_q       <= 1'b0;
            cur_sel_q    <= '0;
            cur_val_q    <= DEF_BASE;
        end else begin
            state_q      <= state_d;
            committed_q  <= committed_d;
            shadow_q     <= shadow_d;
            sel_q        <= sel_d;
            widx_q       <= widx_d;
            tmo_q        <= tmo_d;
            gap_q        <= gap_d;
            edit_q       <= edit_btn;
            next_q       <= next_btn;
            inc_q        <= inc_btn;
            prog_pulse_q <= pulse_d;
            tps_q        <= tps_d;
            tv_q         <= tv_d;
            editing_q    <= (state_d == S_EDIT);
            busy_q       <= (state_d == S_WAIT_SAFE) || (state_d == S_WRITE);
            cur_sel_q    <= sel_d;
            cur_val_q    <= cur_val_d;
        end
    end

    assign prog_pulse          = prog_pulse_q;
    assign time_param_selector = tps_q;
    assign time_value          = tv_q;
    assign editing             = editing_q;
    assign busy                = busy_q;
    assign cur_sel             = cur_sel_q;
    assign cur_val             = cur_val_q;

endmodule

// File: tb/tb_time_param_sequencer.sv
// Self-checking bench for time_param_sequencer. Expected pulse contents are
// queued from a small model of the shadow/committed registers when a
// commit is driven, and are popped by a monitor whenever prog_pulse fires.
module tb_time_param_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable_1Hz = 1'b0;
    logic       edit_btn = 1'b0;
    logic       next_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic       fsm_safe = 1'b0;
    logic       prog_pulse;
    logic [1:0] time_param_selector;
    logic [3:0] time_value;
    logic       editing;
    logic       busy;
    logic [1:0] cur_sel;
    logic [3:0] cur_val;

    int total = 0;
    int bad = 0;
    int pulses = 0;

    logic [5:0] sb [$];
    logic [3:0] m_committed [4];
    logic [3:0] m_shadow [4];
    int         m_sel = 0;

    always #5 clock = ~clock;

    time_param_sequencer #(
        .TIMEOUT_S (15),
        .DEF_BASE  (4'd6),
        .DEF_EXT   (4'd3),
        .DEF_YEL   (4'd2),
        .DEF_WALK  (4'd3)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .enable_1Hz          (enable_1Hz),
        .edit_btn            (edit_btn),
        .next_btn            (next_btn),
        .inc_btn             (inc_btn),
        .fsm_safe            (fsm_safe),
        .prog_pulse          (prog_pulse),
        .time_param_selector (time_param_selector),
        .time_value          (time_value),
        .editing             (editing),
        .busy                (busy),
        .cur_sel             (cur_sel),
        .cur_val             (cur_val)
    );

    // Scoreboard monitor: every pulse must match the oldest queued write.
    always @(posedge clock) begin
        logic [5:0] exp;
        #2;
        if (prog_pulse === 1'b1) begin
            pulses++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse got sel=%0d val=%0d, no write expected",
                         time_param_selector, time_value);
            end else begin
                exp = sb.pop_front();
                if ({time_param_selector, time_value} !== exp) begin
                    bad++;
                    $display("FAIL pulse_data got sel=%0d val=%0d expected sel=%0d val=%0d",
                             time_param_selector, time_value, exp[5:4], exp[3:0]);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic model_defaults();
        m_committed = '{4'd6, 4'd3, 4'd2, 4'd3};
        m_shadow    = '{4'd6, 4'd3, 4'd2, 4'd3};
        m_sel       = 0;
    endtask

    task automatic enter_edit();
        edit_btn = 1'b1;
        step(1);
        edit_btn = 1'b0;
        step(1);
        m_shadow = m_committed;
        m_sel    = 0;
    endtask

    task automatic press_next();
        next_btn = 1'b1;
        step(1);
        next_btn = 1'b0;
        step(1);
        m_sel = (m_sel + 1) % 4;
    endtask

    task automatic press_inc();
        inc_btn = 1'b1;
        step(1);
        inc_btn = 1'b0;
        step(1);
        m_shadow[m_sel] = (m_shadow[m_sel] == 4'd15) ? 4'd1 : m_shadow[m_sel] + 4'd1;
    endtask

    task automatic queue_commit();
        for (int i = 0; i < 4; i++) sb.push_back({2'(i), m_shadow[i]});
        m_committed = m_shadow;
    endtask

    // Commit with fsm_safe already high; records the pulse pattern over the
    // 8 cycles starting at the first pulse and the busy length from there.
    task automatic commit_and_run(output int first, output logic [7:0] pat, output int blen);
        queue_commit();
        edit_btn = 1'b1;
        step(1);
        edit_btn = 1'b0;
        first = -1;
        pat   = '0;
        blen  = 0;
        for (int c = 0; c < 200; c++) begin
            step(1);
            if (first < 0 && prog_pulse === 1'b1) first = c;
            if (first >= 0 && c - first < 8) pat[c - first] = prog_pulse;
            if (first >= 0 && busy === 1'b1) blen++;
            if (first >= 0 && busy !== 1'b1) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        model_defaults();
        sb.delete();
        total++;
        if ({prog_pulse, time_param_selector, time_value, editing, busy, cur_sel, cur_val}
            !== {1'b0, 2'd0, 4'd6, 1'b0, 1'b0, 2'd0, 4'd6}) begin
            bad++;
            $display("FAIL reset_outputs got pp=%b sel=%0d val=%0d ed=%b busy=%b cs=%0d cv=%0d expected 0,0,6,0,0,0,6",
                     prog_pulse, time_param_selector, time_value, editing, busy, cur_sel, cur_val);
        end
    endtask

    task automatic test_no_change_commit();
        int first;
        logic [7:0] pat;
        int blen;
        fsm_safe = 1'b1;
        enter_edit();
        total++;
        if ({editing, busy, cur_sel, cur_val} !== {1'b1, 1'b0, 2'd0, 4'd6}) begin
            bad++;
            $display("FAIL edit_entry got ed=%b busy=%b cs=%0d cv=%0d expected 1,0,0,6",
                     editing, busy, cur_sel, cur_val);
        end
        commit_and_run(first, pat, blen);
        total++;
        if (pat !== 8'b0101_0101) begin
            bad++;
            $display("FAIL pulse_spacing got pattern=%b expected 01010101 (first=%0d)", pat, first);
        end
        total++;
        if (blen !== 8) begin
            bad++;
            $display("FAIL busy_length got %0d expected 8", blen);
        end
        total++;
        if (editing !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL back_to_idle got ed=%b busy=%b expected 0,0", editing, busy);
        end
    endtask

    task automatic test_yellow_wrap();
        int first;
        logic [7:0] pat;
        int blen;
        fsm_safe = 1'b1;
        enter_edit();
        press_next();
        press_next();
        total++;
        if ({cur_sel, cur_val} !== {2'd2, 4'd2}) begin
            bad++;
            $display("FAIL select_yellow got cs=%0d cv=%0d expected 2,2", cur_sel, cur_val);
        end
        for (int k = 0; k < 14; k++) begin
            press_inc();
            total++;
            if (cur_val !== m_shadow[2]) begin
                bad++;
                $display("FAIL yellow_inc_%0d got %0d expected %0d", k, cur_val, m_shadow[2]);
            end
        end
        commit_and_run(first, pat, blen);
        total++;
        if (pat !== 8'b0101_0101) begin
            bad++;
            $display("FAIL yellow_commit_pattern got %b expected 01010101", pat);
        end
        total++;
        if ({cur_sel, cur_val} !== {2'd2, 4'd1}) begin
            bad++;
            $display("FAIL yellow_committed_display got cs=%0d cv=%0d expected 2,1", cur_sel, cur_val);
        end
    endtask

    task automatic test_wait_safe();
        int held_bad = 0;
        int start_pulses;
        fsm_safe = 1'b0;
        enter_edit();
        press_inc();
        queue_commit();
        start_pulses = pulses;
        edit_btn = 1'b1;
        step(1);
        edit_btn = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (prog_pulse !== 1'b0 || busy !== 1'b1) held_bad++;
            step(1);
        end
        total++;
        if (held_bad !== 0 || pulses !== start_pulses) begin
            bad++;
            $display("FAIL wait_safe_hold got %0d bad cycles, %0d pulses expected 0,0",
                     held_bad, pulses - start_pulses);
        end
        fsm_safe = 1'b1;
        step(1);
        total++;
        if (prog_pulse !== 1'b1 || time_param_selector !== 2'd0) begin
            bad++;
            $display("FAIL pulse_after_safe got pp=%b sel=%0d expected 1,0", prog_pulse, time_param_selector);
        end
        for (int c = 0; c < 20 && busy === 1'b1; c++) step(1);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL wait_safe_finish got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_timeout();
        int start_pulses;
        fsm_safe = 1'b1;
        enter_edit();
        press_inc();
        total++;
        if (cur_val !== m_shadow[0]) begin
            bad++;
            $display("FAIL timeout_inc got %0d expected %0d", cur_val, m_shadow[0]);
        end
        start_pulses = pulses;
        for (int t = 0; t < 14; t++) begin
            enable_1Hz = 1'b1;
            step(1);
            enable_1Hz = 1'b0;
            step(1);
        end
        total++;
        if (editing !== 1'b1) begin
            bad++;
            $display("FAIL timeout_early got editing=%b expected 1 after 14 ticks", editing);
        end
        enable_1Hz = 1'b1;
        step(1);
        enable_1Hz = 1'b0;
        step(2);
        total++;
        if ({editing, busy, cur_val} !== {1'b0, 1'b0, m_committed[0]} || pulses !== start_pulses) begin
            bad++;
            $display("FAIL timeout_abort got ed=%b busy=%b cv=%0d pulses=%0d expected 0,0,%0d,0",
                     editing, busy, cur_val, pulses - start_pulses, m_committed[0]);
        end
    endtask

    task automatic test_reset_mid_write();
        int start_pulses;
        int first;
        logic [7:0] pat;
        int blen;
        int found = 0;
        fsm_safe = 1'b1;
        enter_edit();
        press_inc();
        press_inc();
        queue_commit();
        edit_btn = 1'b1;
        step(1);
        edit_btn = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step(1);
            if (prog_pulse === 1'b1 && time_param_selector === 2'd1) begin
                found = 1;
                break;
            end
        end
        total++;
        if (found !== 1) begin
            bad++;
            $display("FAIL reset_wait_pulse1 got no pulse for index 1 expected one within 20 cycles");
        end
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        model_defaults();
        sb.delete();
        start_pulses = pulses;
        total++;
        if ({prog_pulse, time_param_selector, time_value, editing, busy, cur_sel, cur_val}
            !== {1'b0, 2'd0, 4'd6, 1'b0, 1'b0, 2'd0, 4'd6}) begin
            bad++;
            $display("FAIL reset_mid_write_outputs got pp=%b sel=%0d val=%0d ed=%b busy=%b cs=%0d cv=%0d expected 0,0,6,0,0,0,6",
                     prog_pulse, time_param_selector, time_value, editing, busy, cur_sel, cur_val);
        end
        step(20);
        total++;
        if (pulses !== start_pulses) begin
            bad++;
            $display("FAIL reset_no_more_pulses got %0d expected 0", pulses - start_pulses);
        end
        // Defaults must be what gets written by an unchanged commit.
        enter_edit();
        commit_and_run(first, pat, blen);
        total++;
        if (pulses - start_pulses !== 4) begin
            bad++;
            $display("FAIL reset_default_commit got %0d pulses expected 4", pulses - start_pulses);
        end
    endtask

    task automatic test_simultaneous_and_hold();
        int first;
        logic [7:0] pat;
        int blen;
        fsm_safe = 1'b0;
        enter_edit();
        queue_commit();
        edit_btn = 1'b1;
        inc_btn  = 1'b1;
        step(1);
        edit_btn = 1'b0;
        inc_btn  = 1'b0;
        total++;
        if ({editing, busy} !== {1'b0, 1'b1}) begin
            bad++;
            $display("FAIL edit_beats_inc got ed=%b busy=%b expected 0,1", editing, busy);
        end
        step(3);
        fsm_safe = 1'b1;
        for (int c = 0; c < 20 && busy === 1'b1; c++) step(1);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL simultaneous_finish got busy=%b expected 0", busy);
        end
        enter_edit();
        inc_btn = 1'b1;
        step(100);
        inc_btn = 1'b0;
        step(1);
        m_shadow[0] = m_shadow[0] + 4'd1;
        total++;
        if (cur_val !== m_shadow[0]) begin
            bad++;
            $display("FAIL held_inc got %0d expected %0d", cur_val, m_shadow[0]);
        end
        commit_and_run(first, pat, blen);
        total++;
        if (blen !== 8) begin
            bad++;
            $display("FAIL held_commit_busy got %0d expected 8", blen);
        end
    endtask

    initial begin
        test_reset();
        test_no_change_commit();
        test_yellow_wrap();
        test_wait_safe();
        test_timeout();
        test_reset_mid_write();
        test_simultaneous_and_hold();
        step(4);
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_drain got %0d pending writes expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
